chain_seq_ctrl: RTL and testbench
=================================

// Module: chain_seq_ctrl
// PURPOSE
//   Run sequencer for the PRBS -> tx filter -> noise -> ch filter -> AA filter chain.
//   Holds the datapath in sync reset, issues the baud strobe (1 per OVERSAMP clocks),
//   masks the pipeline warm-up, and marks the decimated sample phase for capture/BER logic.
//   Counts N captured symbols, then reports done; sits between the host/test control and the datapath.
// PARAMETERS
//   OVERSAMP   4   clocks per symbol; power of 2, >=2
//   NB_NSYM    24  width of symbol-count request/status
//   FLUSH_CYC  8   cycles o_soft_rst held in FLUSH (>=1)
//   PIPE_LAT   40  clocks after FLUSH before samples are valid (chain latency, >=1)
//   NB_PHASE   2   width of phase select, = log2(OVERSAMP)
// PORTS
//   clk          in   1         system clock
//   i_reset      in   1         async reset, active-high
//   i_start      in   1         start-run pulse; sampled only in IDLE
//   i_stop       in   1         abort request; level, sampled every cycle
//   i_phase_sel  in   NB_PHASE  decimation phase; latched on accepted start
//   i_n_symbols  in   NB_NSYM   symbols to capture; latched on start; 0 = continuous
//   o_soft_rst   out  1         sync reset to datapath blocks
//   o_en_sym     out  1         baud strobe to PRBS / symbol-rate logic
//   o_samp_valid out  1         1-clk strobe: AA output at selected phase is valid
//   o_busy       out  1         high in FLUSH, WARMUP, RUN
//   o_done       out  1         1-clk pulse on completion of N symbols
//   o_sym_count  out  NB_NSYM   symbols captured in current/last run
// BEHAVIOUR
//   Reset: state=IDLE; o_soft_rst=1; o_en_sym=0; o_samp_valid=0; o_busy=0; o_done=0;
//     o_sym_count=0; baud cnt=0; latched phase/N=0. All outputs registered.
//   FSM:
//   - IDLE: o_soft_rst=1. i_start&!i_stop -> FLUSH; latch phase, N; clear o_sym_count, baud cnt.
//   - FLUSH: o_soft_rst=1 for exactly FLUSH_CYC clocks -> WARMUP.
//   - WARMUP: o_soft_rst=0; baud cnt free-runs 0..OVERSAMP-1, wraps; PIPE_LAT clocks -> RUN.
//   - RUN: baud cnt continues (no restart); o_samp_valid when cnt==latched phase.
//       o_sym_count += 1 per o_samp_valid, saturating at all-ones.
//       N!=0 and valid with count==N-1 -> DONE (count ends at N).
//   - DONE: o_done=1 for one clock, o_soft_rst=1 -> IDLE.
//   o_en_sym=1 when cnt==0 in WARMUP and RUN; first strobe on first WARMUP clock.
//   o_soft_rst=1 in IDLE, FLUSH, DONE. o_busy=1 in FLUSH, WARMUP, RUN.
//   i_stop in FLUSH/WARMUP/RUN: next state IDLE, no o_done, o_sym_count holds value.
//   i_start outside IDLE: ignored. i_start & i_stop in same IDLE clock: stop wins.
//   N=0: RUN until i_stop; count saturates, never wraps.
//   N=1: exactly one o_samp_valid, then DONE.
//   i_phase_sel / i_n_symbols changes mid-run: no effect until next start.
//   i_reset asserted mid-run: immediate return to reset values; no done pulse.
// CONFIGURATION
//   CHAIN_SEQ_AUTORESTART_EN defined: DONE -> FLUSH (not IDLE); N, phase re-used;
//     o_sym_count clears on FLUSH entry; o_done still pulses; i_stop high in DONE -> IDLE.
//   Not defined: DONE -> IDLE always; new i_start needed per run.
// TESTING
//   1 reset, no start 100 clks -> o_soft_rst=1, all other outputs 0, IDLE held.
//   2 start, N=10, phase=2 -> soft_rst 8 clks; 40 warm-up clks; 10 samp_valid 4 clks apart
//     at cnt==2; o_done 1 clk; o_sym_count=10; o_busy low after done.
//   3 start N=0 phase=0, stop after 1000 RUN clks -> 250 samp_valid, no o_done, count=250.
//   4 stop mid-WARMUP -> IDLE next clk, zero samp_valid, o_done never asserted.
//   5 start+stop same clk in IDLE -> stays IDLE; start during RUN -> no restart, count continues.
//   6 AUTORESTART_EN, N=4 -> 3 back-to-back runs: each 8 flush + 40 warm-up + 4 samples, 3 done pulses.

Source files
------------

// File: rtl/chain_seq_ctrl.sv
// Run sequencer for the PRBS -> tx filter -> noise -> ch filter -> AA filter chain.
// Latency: all outputs registered; each output reflects the FSM state of the same cycle.
// Backpressure: none; i_stop aborts at any busy cycle, i_start is honoured only in IDLE.
//
// Ports:
//   clk, i_reset (async, active-high)
//   i_start / i_stop            host run control (start pulse, stop level)
//   i_phase_sel / i_n_symbols   run configuration, latched on an accepted start
//   o_soft_rst                  sync reset to the datapath (IDLE, FLUSH, DONE)
//   o_en_sym                    baud strobe, one per OVERSAMP clocks in WARMUP/RUN
//   o_samp_valid                decimated-phase strobe during RUN
//   o_busy / o_done             run in progress / one-clock completion pulse
//   o_sym_count                 symbols captured in the current or last run
// Build option: define CHAIN_SEQ_AUTORESTART_EN to make DONE re-enter FLUSH with the
// same N and phase (i_stop high in DONE returns to IDLE instead).
module chain_seq_ctrl #(
    parameter int OVERSAMP  = 4,
    parameter int NB_NSYM   = 24,
    parameter int FLUSH_CYC = 8,
    parameter int PIPE_LAT  = 40,
    parameter int NB_PHASE  = 2
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [NB_PHASE-1:0] i_phase_sel,
    input  logic [NB_NSYM-1:0]  i_n_symbols,
    output logic                o_soft_rst,
    output logic                o_en_sym,
    output logic                o_samp_valid,
    output logic                o_busy,
    output logic                o_done,
    output logic [NB_NSYM-1:0]  o_sym_count
);

    localparam int TMAX = (PIPE_LAT > FLUSH_CYC) ? PIPE_LAT : FLUSH_CYC;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0]       FLUSH_LAST = TW'(FLUSH_CYC - 1);
    localparam logic [TW-1:0]       WARM_LAST  = TW'(PIPE_LAT - 1);
    localparam logic [NB_PHASE-1:0] CNT_LAST   = NB_PHASE'(OVERSAMP - 1);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_WARMUP, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [NB_PHASE-1:0] cnt_q, cnt_d;
    logic [NB_PHASE-1:0] phase_q, phase_d;
    logic [NB_NSYM-1:0]  n_q, n_d;
    logic [NB_NSYM-1:0]  sym_count_q, sym_count_d;
    logic                soft_rst_q, soft_rst_d;
    logic                en_sym_q, en_sym_d;
    logic                samp_vld_q, samp_vld_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // State register (and every other flop)
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            cnt_q       <= '0;
            phase_q     <= '0;
            n_q         <= '0;
            sym_count_q <= '0;
            soft_rst_q  <= 1'b1;
            en_sym_q    <= 1'b0;
            samp_vld_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            n_q         <= n_d;
            sym_count_q <= sym_count_d;
            soft_rst_q  <= soft_rst_d;
            en_sym_q    <= en_sym_d;
            samp_vld_q  <= samp_vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start && !i_stop) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (i_stop)                   state_d = S_IDLE;
                else if (tmr_q == FLUSH_LAST) state_d = S_WARMUP;
            end
            S_WARMUP: begin
                if (i_stop)                  state_d = S_IDLE;
                else if (tmr_q == WARM_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                // sym_count_q already includes the strobe currently on o_samp_valid
                if (i_stop)
                    state_d = S_IDLE;
                else if (samp_vld_q && (n_q != '0) && (sym_count_q == n_q))
                    state_d = S_DONE;
            end
            S_DONE: begin
`ifdef CHAIN_SEQ_AUTORESTART_EN
                state_d = i_stop ? S_IDLE : S_FLUSH;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values, all aligned to state_d
    always_comb begin
        tmr_d       = tmr_q;
        cnt_d       = '0;
        phase_d     = phase_q;
        n_d         = n_q;
        sym_count_d = sym_count_q;

        // Phase timer restarts on every state change, counts only while it matters
        if (state_d != state_q)
            tmr_d = '0;
        else if (state_q == S_FLUSH || state_q == S_WARMUP)
            tmr_d = tmr_q + 1'b1;

        // Baud counter holds at 0 outside WARMUP/RUN so WARMUP opens on a strobe,
        // and runs uninterrupted across the WARMUP -> RUN boundary
        if (state_q == S_WARMUP || state_q == S_RUN)
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

        if (state_q == S_IDLE && state_d == S_FLUSH) begin
            phase_d = i_phase_sel;
            n_d     = i_n_symbols;
        end

        soft_rst_d = (state_d == S_IDLE) || (state_d == S_FLUSH) || (state_d == S_DONE);
        busy_d     = (state_d == S_FLUSH) || (state_d == S_WARMUP) || (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
        en_sym_d   = ((state_d == S_WARMUP) || (state_d == S_RUN)) && (cnt_d == '0);
        samp_vld_d = (state_d == S_RUN) && (cnt_d == phase_q);

        if (state_d == S_FLUSH && state_q != S_FLUSH)
            sym_count_d = '0;
        else if (samp_vld_d && (sym_count_q != '1))
            sym_count_d = sym_count_q + 1'b1;
    end

    assign o_soft_rst   = soft_rst_q;
    assign o_en_sym     = en_sym_q;
    assign o_samp_valid = samp_vld_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_sym_count  = sym_count_q;

endmodule

// File: tb/tb_chain_seq_ctrl.sv
module tb_chain_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  phase_sel = '0;
    logic [23:0] n_sym = '0;
    logic        soft_rst, en_sym, samp_valid, busy, done;
    logic [23:0] sym_count;

    int n_checks = 0;
    int n_pass   = 0;

    chain_seq_ctrl dut (
        .clk         (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_phase_sel (phase_sel),
        .i_n_symbols (n_sym),
        .o_soft_rst  (soft_rst),
        .o_en_sym    (en_sym),
        .o_samp_valid(samp_valid),
        .o_busy      (busy),
        .o_done      (done),
        .o_sym_count (sym_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After return, the bench is in cycle c=0 (first FLUSH cycle if accepted)
    task automatic do_start(input logic [23:0] n, input logic [1:0] ph);
        n_sym     = n;
        phase_sel = ph;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        step();
        n_checks++;
        if ({soft_rst, en_sym, samp_valid, busy, done} !== 5'b10000)
            $display("FAIL rst_outputs: got %b want 10000", {soft_rst, en_sym, samp_valid, busy, done});
        else n_pass++;
        n_checks++;
        if (sym_count !== 24'd0) $display("FAIL rst_count: got %0d want 0", sym_count);
        else n_pass++;
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if ({soft_rst, en_sym, samp_valid, busy, done} !== 5'b10000 || sym_count !== 24'd0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL idle_hold: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_run_n10();
        int soft_low = -1, en_warm = 0, vcnt = 0, vfirst = -1, vlast = -1, gap_bad = 0;
        int dcnt = 0, dfirst = -1;
        logic en8 = 1'b0, busy_at_done = 1'b1;
        logic [23:0] cnt_at_done = '0;
        do_start(24'd10, 2'd2);
        for (int c = 0; c < 120; c++) begin
            if (soft_low < 0 && soft_rst === 1'b0) soft_low = c;
            if (c == 8) en8 = en_sym;
            if (c >= 8 && c < 48 && en_sym === 1'b1) en_warm++;
            if (samp_valid === 1'b1) begin
                if (vlast >= 0 && c - vlast != 4) gap_bad++;
                if (vfirst < 0) vfirst = c;
                vlast = c;
                vcnt++;
            end
            stop = 1'b0;
            if (done === 1'b1) begin
                if (dfirst < 0) begin
                    dfirst = c;
                    busy_at_done = busy;
                    cnt_at_done = sym_count;
                end
                dcnt++;
                stop = 1'b1;
            end
            step();
        end
        stop = 1'b0;
        n_checks++; if (soft_low != 8) $display("FAIL flush_len: got %0d want 8", soft_low); else n_pass++;
        n_checks++; if (en8 !== 1'b1) $display("FAIL first_baud: got %b want 1", en8); else n_pass++;
        n_checks++; if (en_warm != 10) $display("FAIL warm_baud_cnt: got %0d want 10", en_warm); else n_pass++;
        n_checks++; if (vcnt != 10) $display("FAIL n10_valids: got %0d want 10", vcnt); else n_pass++;
        n_checks++; if (vfirst != 50) $display("FAIL n10_first_valid: got %0d want 50", vfirst); else n_pass++;
        n_checks++; if (vlast != 86) $display("FAIL n10_last_valid: got %0d want 86", vlast); else n_pass++;
        n_checks++; if (gap_bad != 0) $display("FAIL n10_spacing: got %0d bad gaps want 0", gap_bad); else n_pass++;
        n_checks++; if (dfirst != 87 || dcnt != 1) $display("FAIL n10_done: got at %0d x%0d want at 87 x1", dfirst, dcnt); else n_pass++;
        n_checks++; if (busy_at_done !== 1'b0) $display("FAIL n10_busy_done: got %b want 0", busy_at_done); else n_pass++;
        n_checks++; if (cnt_at_done !== 24'd10) $display("FAIL n10_count: got %0d want 10", cnt_at_done); else n_pass++;
        n_checks++; if (busy !== 1'b0 || sym_count !== 24'd10) $display("FAIL n10_after: got busy %b cnt %0d want 0 10", busy, sym_count); else n_pass++;
    endtask

    task automatic test_continuous();
        int vcnt = 0, dcnt = 0;
        logic busy1048 = 1'b1;
        do_start(24'd0, 2'd0);
        for (int c = 0; c < 1060; c++) begin
            if (samp_valid === 1'b1) vcnt++;
            if (done === 1'b1) dcnt++;
            if (c == 1048) busy1048 = busy;
            stop = (c == 1047);
            step();
        end
        stop = 1'b0;
        n_checks++; if (vcnt != 250) $display("FAIL cont_valids: got %0d want 250", vcnt); else n_pass++;
        n_checks++; if (dcnt != 0) $display("FAIL cont_no_done: got %0d want 0", dcnt); else n_pass++;
        n_checks++; if (busy1048 !== 1'b0) $display("FAIL cont_stop_idle: got %b want 0", busy1048); else n_pass++;
        n_checks++; if (sym_count !== 24'd250) $display("FAIL cont_count: got %0d want 250", sym_count); else n_pass++;
    endtask

    task automatic test_stop_warmup();
        int vcnt = 0, dcnt = 0;
        logic busy21 = 1'b1, soft21 = 1'b0;
        do_start(24'd5, 2'd0);
        for (int c = 0; c < 100; c++) begin
            if (samp_valid === 1'b1) vcnt++;
            if (done === 1'b1) dcnt++;
            if (c == 21) begin busy21 = busy; soft21 = soft_rst; end
            stop = (c == 20);
            step();
        end
        stop = 1'b0;
        n_checks++; if (busy21 !== 1'b0 || soft21 !== 1'b1) $display("FAIL warm_stop: got busy %b soft %b want 0 1", busy21, soft21); else n_pass++;
        n_checks++; if (vcnt != 0 || dcnt != 0) $display("FAIL warm_stop_quiet: got valid %0d done %0d want 0 0", vcnt, dcnt); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int busy_hi = 0, vcnt = 0, wrong_ph = 0, busy_lo = 0, dcnt = 0;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy !== 1'b0) busy_hi++;
            step();
        end
        n_checks++; if (busy_hi != 0) $display("FAIL start_stop_same: got %0d busy cycles want 0", busy_hi); else n_pass++;
        do_start(24'd0, 2'd1);
        for (int c = 0; c <= 100; c++) begin
            if (samp_valid === 1'b1) begin
                vcnt++;
                if ((c - 48) % 4 != 1) wrong_ph++;
            end
            if (busy !== 1'b1) busy_lo++;
            if (done === 1'b1) dcnt++;
            if (c == 60) begin start = 1'b1; phase_sel = 2'd3; n_sym = 24'd2; end
            else start = 1'b0;
            if (c < 100) step();
        end
        start = 1'b0;
        n_checks++; if (vcnt != 13 || sym_count !== 24'd13) $display("FAIL midrun_start_count: got %0d/%0d want 13", vcnt, sym_count); else n_pass++;
        n_checks++; if (wrong_ph != 0) $display("FAIL midrun_phase_hold: got %0d off-phase want 0", wrong_ph); else n_pass++;
        n_checks++; if (busy_lo != 0 || dcnt != 0) $display("FAIL midrun_no_restart: got busy-low %0d done %0d want 0 0", busy_lo, dcnt); else n_pass++;
        stop = 1'b1; step(); stop = 1'b0; step();
        n_checks++; if (busy !== 1'b0 || sym_count !== 24'd13) $display("FAIL stop_hold_count: got busy %b cnt %0d want 0 13", busy, sym_count); else n_pass++;
    endtask

    task automatic test_single();
        int vcnt = 0, vfirst = -1, dcnt = 0, dfirst = -1, busy_after = 0;
        do_start(24'd1, 2'd3);
        for (int c = 0; c < 120; c++) begin
            if (samp_valid === 1'b1) begin vcnt++; if (vfirst < 0) vfirst = c; end
            if (c > 52 && busy !== 1'b0) busy_after++;
            stop = 1'b0;
            if (done === 1'b1) begin dcnt++; if (dfirst < 0) dfirst = c; stop = 1'b1; end
            step();
        end
        stop = 1'b0;
        n_checks++; if (vcnt != 1 || vfirst != 51) $display("FAIL n1_valid: got %0d at %0d want 1 at 51", vcnt, vfirst); else n_pass++;
        n_checks++; if (dcnt != 1 || dfirst != 52) $display("FAIL n1_done: got %0d at %0d want 1 at 52", dcnt, dfirst); else n_pass++;
        n_checks++; if (busy_after != 0 || sym_count !== 24'd1) $display("FAIL n1_idle: got busy %0d cnt %0d want 0 1", busy_after, sym_count); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int dcnt = 0;
        do_start(24'd3, 2'd0);
        for (int c = 0; c < 55; c++) begin
            if (done === 1'b1) dcnt++;
            step();
        end
        n_checks++; if (sym_count !== 24'd2 || busy !== 1'b1) $display("FAIL pre_reset: got cnt %0d busy %b want 2 1", sym_count, busy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({soft_rst, en_sym, samp_valid, busy, done} !== 5'b10000 || sym_count !== 24'd0 || dcnt != 0)
            $display("FAIL async_reset: got %b cnt %0d done %0d want 10000 0 0", {soft_rst, en_sym, samp_valid, busy, done}, sym_count, dcnt);
        else n_pass++;
        step();
        rst = 1'b0;
        step();
    endtask

`ifdef CHAIN_SEQ_AUTORESTART_EN
    task automatic test_autorestart();
        int vcnt = 0, dcnt = 0, dfirst = -1, dlast = -1;
        do_start(24'd4, 2'd0);
        for (int c = 0; c < 200; c++) begin
            if (samp_valid === 1'b1) vcnt++;
            stop = 1'b0;
            if (done === 1'b1) begin
                dcnt++;
                if (dfirst < 0) dfirst = c;
                dlast = c;
                if (dcnt == 3) stop = 1'b1;
            end
            step();
        end
        stop = 1'b0;
        n_checks++; if (dcnt != 3) $display("FAIL auto_dones: got %0d want 3", dcnt); else n_pass++;
        n_checks++; if (vcnt != 12) $display("FAIL auto_valids: got %0d want 12", vcnt); else n_pass++;
        n_checks++; if (dfirst != 61 || dlast != 185) $display("FAIL auto_timing: got %0d..%0d want 61..185", dfirst, dlast); else n_pass++;
        n_checks++; if (busy !== 1'b0 || sym_count !== 24'd4) $display("FAIL auto_stop: got busy %b cnt %0d want 0 4", busy, sym_count); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_run_n10();
        test_continuous();
        test_stop_warmup();
        test_start_ignored();
        test_single();
        test_reset_midrun();
`ifdef CHAIN_SEQ_AUTORESTART_EN
        test_autorestart();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
